// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-pass logical shifter behind valid/ready handshakes
module shift_sequencer #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 4,
  parameter int STEP   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AMT_W-1:0]  out_passes,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [AMT_W-1:0]  rem_q;
  logic [AMT_W-1:0]  pass_cnt;
  logic              dir_q;
  logic [AMT_W-1:0]  step;
  logic [DATA_W-1:0] shifted;

  // Single zero-fill shift stage: moves at most STEP positions per pass
  always_comb begin
    step    = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    shifted = dir_q ? (data_q >> step) : (data_q << step);
  end

  // Request side is only open in IDLE and never while reset is asserted
  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state != IDLE);

  // Sequencer: accept, shift pass by pass, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_q     <= '0;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      pass_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_passes <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            rem_q    <= in_amt;
            dir_q    <= in_dir;
            pass_cnt <= '0;
            state    <= (in_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data_q   <= shifted;
          rem_q    <= rem_q - step;
          pass_cnt <= pass_cnt + 1'b1;
          if (rem_q == step) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_data   <= shifted;
            out_passes <= pass_cnt + 1'b1;
          end
        end
        DONE: begin
          // A zero-amount job arrives here with out_valid still low; the
          // result is published one edge later so latency is never zero.
          if (!out_valid) begin
            out_valid  <= 1'b1;
            out_data   <= data_q;
            out_passes <= pass_cnt;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_amt = '0;
  logic       in_dir = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [3:0] out_passes;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic [3:0] p;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   prev_valid = 1'b0;

  shift_sequencer #(.DATA_W(8), .AMT_W(4), .STEP(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_passes(out_passes), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          if (!prev_valid) chk("latency", cyc - sb[0].acc, sb[0].lat);
          chk("out_data", out_data, sb[0].d);
          chk("out_passes", out_passes, sb[0].p);
          chk("in_ready_in_done", in_ready, 0);
          chk("busy_in_done", busy, 1);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = out_valid && !out_ready;
    end
  end

  task automatic wait_in_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (!ok) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic do_job(input logic [7:0] d, input logic [3:0] a, input logic dir,
                        input logic [7:0] ed, input logic [3:0] ep, input int lat,
                        output int acc);
    exp_t e;
    bit   ok;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dir;
    wait_in_ready(ok);
    acc = -1;
    if (ok) begin
      @(posedge clk);
      #1;
      acc = cyc;
      e.d = ed; e.p = ep; e.lat = lat; e.acc = acc;
      sb.push_back(e);
    end
    in_valid = 1'b0;
    in_data = 8'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom);
  endtask

  task automatic wait_drain;
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int  acc;
    int  c;
    bit  ok;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_passes", out_passes, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    do_job(8'hA5, 4'd0, 1'b0, 8'hA5, 4'd0, 1, acc);
    do_job(8'h01, 4'd7, 1'b0, 8'h80, 4'd3, 3, acc);
    do_job(8'hFF, 4'd15, 1'b1, 8'h00, 4'd5, 5, acc);
    do_job(8'h81, 4'd3, 1'b1, 8'h10, 4'd1, 1, acc);
    do_job(8'h03, 4'd6, 1'b0, 8'hC0, 4'd2, 2, acc);
    wait_drain();

    // Backpressure: hold the result 10 cycles with a new request pending
    out_ready = 1'b0;
    do_job(8'h0F, 4'd4, 1'b0, 8'hF0, 4'd2, 2, acc);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b1; in_data = 8'hB4; in_amt = 4'd5; in_dir = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    c = cyc;
    do_job(8'hB4, 4'd5, 1'b1, 8'h05, 4'd2, 2, acc);
    chk("bp_reaccept_cycle", acc, c + 2);
    wait_drain();

    // Reset during the second pass of a 12-position shift
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; in_amt = 4'd12; in_dir = 1'b0;
    wait_in_ready(ok);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_job(8'h80, 4'd3, 1'b1, 8'h10, 4'd1, 1, acc);
    wait_drain();
    repeat (8) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
